// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and width helper shared by the FIFO write arbiter.
package fifo_arb_pkg;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;
   // Ceiling log2, floored at 1 so degenerate parameters still yield a usable vector
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set request scanning ptr+1, ptr+2, ... mod n.
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter int n = 4,
   localparam int idw = clog2(n)
) (
   input  logic [n-1:0]   req_i,
   input  logic [idw-1:0] ptr_i,
   output logic           found_o,
   output logic [idw-1:0] index_o
);
   // Scan from the far end so the nearest candidate overwrites the rest
   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      for (int k = n; k >= 1; k--) begin
         if (req_i[(int'(ptr_i) + k) % n]) begin
            found_o = 1'b1;
            index_o = idw'((int'(ptr_i) + k) % n);
         end
      end
   end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin share of one FIFO write port with bounded burst lock.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int n = 4,
   parameter int width = 8,
   parameter int max_burst = 16,
   localparam int idw = clog2(n),
   localparam int bw = clog2(max_burst)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [n*width-1:0] req_data_i,
   input  logic [n-1:0]       req_valid_i,
   output logic [n-1:0]       req_ready_o,
   output logic [width-1:0]   din_o,
   output logic               din_valid_o,
   input  logic               din_ready_i,
   output logic [idw-1:0]     grant_id_o,
   output logic               grant_active_o
);
   logic [0:0]     state_q, state_d;
   logic [idw-1:0] grant_q, grant_d, rr_q, rr_d, pick_idx, pick_ptr;
   logic [bw-1:0]  cnt_q, cnt_d;
   logic [n-1:0]   pick_req;
   logic           cur_v, xfer, rel, arb, found;
   assign cur_v          = req_valid_i[grant_q];
   assign grant_active_o = state_q == ST_GRANT;
   assign grant_id_o     = grant_q;
   assign din_o          = req_data_i[int'(grant_q)*width +: width];
   assign din_valid_o    = grant_active_o & cur_v;
   assign xfer           = din_valid_o & din_ready_i;
   assign rel            = grant_active_o & (~cur_v | (xfer & (cnt_q == bw'(max_burst - 1))));
   assign arb            = (state_q == ST_IDLE) | rel;
   // On release the outgoing owner is masked out; if nobody else wants the port
   // we drop to IDLE and regrant it from there, costing one bubble cycle.
   assign pick_req = rel ? req_valid_i & ~(n'(1) << grant_q) : req_valid_i;
   assign pick_ptr = rel ? grant_q : rr_q;
   rr_priority_picker #(.n(n)) u_pick (
      .req_i  (pick_req),
      .ptr_i  (pick_ptr),
      .found_o(found),
      .index_o(pick_idx)
   );
   always_comb begin
      state_d = arb ? (found ? ST_GRANT : ST_IDLE) : state_q;
      grant_d = (arb & found) ? pick_idx : grant_q;
      cnt_d   = arb ? '0 : cnt_q + bw'(xfer);
      rr_d    = rel ? grant_q : rr_q;
   end
   always_comb
      for (int i = 0; i < n; i++)
         req_ready_o[i] = grant_active_o & (grant_q == idw'(i)) & din_ready_i;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= idw'(n - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenarios with per-requester sources and a FIFO word scoreboard.
module tb_fifo_write_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] req_data;
   logic [3:0]  req_valid, req_ready;
   logic [7:0]  din;
   logic        din_valid, din_ready;
   logic [1:0]  grant_id;
   logic        grant_active;
   logic [15:0] d2;
   logic [1:0]  v2, r2;
   logic [7:0]  dout2;
   logic        dv2, ga2;
   logic [0:0]  gid2;
   int          checks = 0, failures = 0, cyc = 0, nwr = 0;
   int          bi, nb, c;
   logic [7:0]  exp_q[$];
   int          wr_cyc[$];
   logic [3:0]  en, pend;
   int          remain[4];
   logic [5:0]  seq[4], push_seq[4];

   fifo_write_arbiter #(.n(4), .width(8), .max_burst(16)) dut (
      .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_valid_i(req_valid),
      .req_ready_o(req_ready), .din_o(din), .din_valid_o(din_valid), .din_ready_i(din_ready),
      .grant_id_o(grant_id), .grant_active_o(grant_active)
   );
   fifo_write_arbiter #(.n(2), .width(8), .max_burst(1)) dut2 (
      .clk_i(clk), .rst_i(rst), .req_data_i(d2), .req_valid_i(v2),
      .req_ready_o(r2), .din_o(dout2), .din_valid_o(dv2), .din_ready_i(1'b1),
      .grant_id_o(gid2), .grant_active_o(ga2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic update_src();
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = en[i] && remain[i] > 0;
         req_data[i*8 +: 8] = {2'(i), seq[i]};
      end
   endtask

   task automatic push(input int id, input int cnt);
      for (int k = 0; k < cnt; k++) begin
         exp_q.push_back({2'(id), push_seq[id]});
         push_seq[id]++;
      end
   endtask

   // Observe on the falling edge, then let sources retire accepted words after the rising edge
   task automatic step();
      @(negedge clk);
      cyc++;
      check("onehot_ready", 32'($countones(req_ready) <= 1 && $countones(r2) <= 1), 1);
      check("valid_wo_grant", 32'(din_valid & ~grant_active), 0);
      if (din_valid && din_ready) begin
         wr_cyc.push_back(cyc);
         nwr++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_write got=%0h exp=none", din);
         end else check("fifo_word", din, exp_q.pop_front());
      end
      pend = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (pend[i]) begin
            seq[i]++;
            remain[i]--;
         end
      update_src();
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) step();
      step();
      step();
      check(tag, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = '0;
      for (int i = 0; i < 4; i++) remain[i] = 0;
      update_src();
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      en = '0;
      pend = '0;
      din_ready = 1'b1;
      v2 = '0;
      d2 = {8'h5B, 8'hA4};
      for (int i = 0; i < 4; i++) begin
         seq[i] = '0;
         push_seq[i] = '0;
         remain[i] = 0;
      end
      update_src();
      do_reset();
      check("rst_state", {din_valid, grant_active, grant_id, req_ready}, 0);
      check("rst_rr", dut.rr_q, 3);
      // single requester, 20 words: burst of 16, one bubble, then 4
      push(0, 20);
      bi = wr_cyc.size();
      c = cyc;
      en[0] = 1'b1;
      remain[0] = 20;
      update_src();
      step();
      check("t1_grant", {grant_active, grant_id}, 3'b100);
      drain("t1_drain");
      check("t1_count", wr_cyc.size() - bi, 20);
      check("t1_latency", wr_cyc[bi] - c, 2);
      check("t1_burst", wr_cyc[bi+15] - wr_cyc[bi], 15);
      check("t1_bubble", wr_cyc[bi+16] - wr_cyc[bi+15], 2);
      check("t1_tail", wr_cyc[bi+19] - wr_cyc[bi+16], 3);
      // all requesters: order 0,1,2,3,0 back to back
      do_reset();
      push(0, 16); push(1, 16); push(2, 16); push(3, 16); push(0, 16);
      bi = wr_cyc.size();
      en = 4'b1111;
      remain[0] = 32; remain[1] = 16; remain[2] = 16; remain[3] = 16;
      update_src();
      drain("t2_drain");
      check("t2_count", wr_cyc.size() - bi, 80);
      check("t2_no_bubble", wr_cyc[bi+79] - wr_cyc[bi], 79);
      // owner drops valid early, next requester takes over
      do_reset();
      push(2, 5); push(3, 4);
      nb = nwr;
      bi = wr_cyc.size();
      en = 4'b1100;
      remain[2] = 5; remain[3] = 4;
      update_src();
      for (int k = 0; k < 50 && !(grant_active && grant_id == 2'd3); k++) step();
      check("t3_grant3", {grant_active, grant_id}, 3'b111);
      check("t3_words_from2", nwr - nb, 5);
      check("t3_rr", dut.rr_q, 2);
      drain("t3_drain");
      check("t3_gap", wr_cyc[bi+5] - wr_cyc[bi+4], 2);
      // FIFO full for 7 cycles mid-burst
      do_reset();
      push(1, 20);
      nb = nwr;
      bi = wr_cyc.size();
      en[1] = 1'b1;
      remain[1] = 20;
      update_src();
      for (int k = 0; k < 50 && nwr - nb < 4; k++) step();
      din_ready = 1'b0;
      for (int s = 0; s < 7; s++) begin
         step();
         check("t4_hold", {grant_active, grant_id}, 3'b101);
         check("t4_ready", req_ready, 0);
         check("t4_cnt", dut.cnt_q, 4);
      end
      din_ready = 1'b1;
      drain("t4_drain");
      check("t4_stall_gap", wr_cyc[bi+4] - wr_cyc[bi+3], 8);
      check("t4_burst_span", wr_cyc[bi+15] - wr_cyc[bi], 22);
      check("t4_release", wr_cyc[bi+16] - wr_cyc[bi+15], 2);
      // max_burst=1, n=2: strict alternation, one word per grant
      do_reset();
      v2 = 2'b11;
      step();
      for (int k = 0; k < 6; k++) begin
         check("t5_grant", {ga2, gid2}, {1'b1, 1'(k % 2)});
         check("t5_word", {dv2, dout2}, {1'b1, (k % 2 == 1) ? 8'h5B : 8'hA4});
         check("t5_ready", r2, (k % 2 == 1) ? 2'b10 : 2'b01);
         step();
      end
      v2 = '0;
      // reset during burst to 3: the word in flight at the reset edge is still written
      do_reset();
      push(3, 10);
      nb = nwr;
      en[3] = 1'b1;
      remain[3] = 30;
      update_src();
      for (int k = 0; k < 50 && nwr - nb < 9; k++) step();
      rst = 1'b1;
      step();
      check("t6_dropped", {grant_active, dut.rr_q}, 3'b011);
      rst = 1'b0;
      en = 4'b1111;
      remain[0] = 1; remain[1] = 1; remain[2] = 1; remain[3] = 20;
      push(0, 1); push(1, 1); push(2, 1); push(3, 20);
      update_src();
      step();
      check("t6_first", {grant_active, grant_id}, 3'b100);
      drain("t6_drain");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
